// File: rtl/comp4_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : comp4_pkg
//  Purpose  : Shared defaults and operand type for the comp4 comparator.
//  Revision : 1.0  initial release
// ============================================================================
package comp4_pkg;

    localparam int COMP4_WIDTH = 4;
    localparam int COMP4_CNT_W = 8;

    typedef logic [COMP4_WIDTH-1:0] operand_t;

endpackage : comp4_pkg
`default_nettype wire

// File: rtl/comp4_slice.sv
`default_nettype none
// ============================================================================
//  Module   : comp4_slice
//  Purpose  : One bit of an MSB-first magnitude-compare cascade. A bit only
//             decides the result while every more significant bit was equal.
//  Revision : 1.0  initial release
// ============================================================================
module comp4_slice
    import comp4_pkg::*;
(
    input  logic a_i,
    input  logic b_i,
    input  logic eq_in,
    input  logic gt_in,
    output logic eq_out,
    output logic gt_out
);

    // Equal so far only if all higher bits matched and this bit matches too;
    // greater once a higher bit decided it, or this bit decides it now.
    always_comb begin
        eq_out = eq_in & ~(a_i ^ b_i);
        gt_out = gt_in | (eq_in & a_i & ~b_i);
    end

endmodule : comp4_slice
`default_nettype wire

// File: rtl/comp4.sv
`default_nettype none
// ============================================================================
//  Module   : comp4
//  Purpose  : Unsigned WIDTH-bit comparator with combinational eq/gt/lt and a
//             registered monitor (eq_q, rise/fall pulses, saturating count of
//             matching cycles).
//  Revision : 1.0  initial release
// ============================================================================
module comp4
    import comp4_pkg::*;
#(
    parameter int WIDTH = COMP4_WIDTH,
    parameter int CNT_W = COMP4_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic             eq_q,
    output logic             eq_rise,
    output logic             eq_fall,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    // Cascade nodes: index 0 is the chain input, index WIDTH the final result.
    logic [WIDTH:0] w_eq_chain;
    logic [WIDTH:0] w_gt_chain;

    logic             r_eq_q;
    logic             r_eq_rise;
    logic             r_eq_fall;
    logic [CNT_W-1:0] r_match_cnt;

    assign w_eq_chain[0] = 1'b1;
    assign w_gt_chain[0] = 1'b0;

    // Stage i compares operand bit WIDTH-1-i, so the MSB is resolved first.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_chain
            comp4_slice u_slice (
                .a_i    (a[WIDTH-1-i]),
                .b_i    (b[WIDTH-1-i]),
                .eq_in  (w_eq_chain[i]),
                .gt_in  (w_gt_chain[i]),
                .eq_out (w_eq_chain[i+1]),
                .gt_out (w_gt_chain[i+1])
            );
        end
    endgenerate

    // Combinational results come straight off the cascade, untouched by clk/reset.
    always_comb begin
        eq = w_eq_chain[WIDTH];
        gt = w_gt_chain[WIDTH];
        lt = ~w_eq_chain[WIDTH] & ~w_gt_chain[WIDTH];
    end

    // Registered copy of eq and its edge pulses; pulses line up with the eq_q change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_eq_q    <= 1'b0;
            r_eq_rise <= 1'b0;
            r_eq_fall <= 1'b0;
        end else begin
            r_eq_q    <= eq;
            r_eq_rise <= eq & ~r_eq_q;
            r_eq_fall <= ~eq & r_eq_q;
        end
    end

    // Match counter: clear beats increment; sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_match_cnt <= '0;
        end else if (clr) begin
            r_match_cnt <= '0;
        end else if (eq && (r_match_cnt != c_cnt_max)) begin
            r_match_cnt <= r_match_cnt + 1'b1;
        end
    end

    assign eq_q      = r_eq_q;
    assign eq_rise   = r_eq_rise;
    assign eq_fall   = r_eq_fall;
    assign match_cnt = r_match_cnt;

endmodule : comp4
`default_nettype wire

// File: tb/tb_comp4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_comp4
//  Purpose  : Directed self-checking bench for comp4 (default widths plus a
//             CNT_W=2 instance sharing the same stimulus).
//  Revision : 1.0  initial release
// ============================================================================
module tb_comp4;

    logic       clk;
    logic       clk_en;
    logic       rst_n;
    logic       clr;
    logic [3:0] a;
    logic [3:0] b;

    logic       eq, gt, lt, eq_q, eq_rise, eq_fall;
    logic [7:0] match_cnt;

    logic       s_eq, s_gt, s_lt, s_eq_q, s_eq_rise, s_eq_fall;
    logic [1:0] s_match_cnt;

    int n_checks;
    int n_errors;

    comp4 u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .clr       (clr),
        .eq        (eq),
        .gt        (gt),
        .lt        (lt),
        .eq_q      (eq_q),
        .eq_rise   (eq_rise),
        .eq_fall   (eq_fall),
        .match_cnt (match_cnt)
    );

    comp4 #(.WIDTH(4), .CNT_W(2)) u_dut_sat (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .clr       (clr),
        .eq        (s_eq),
        .gt        (s_gt),
        .lt        (s_lt),
        .eq_q      (s_eq_q),
        .eq_rise   (s_eq_rise),
        .eq_fall   (s_eq_fall),
        .match_cnt (s_match_cnt)
    );

    initial clk = 1'b0;
    always #5 if (clk_en) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor state check for the default-width instance.
    task automatic check_mon(input string tag, input logic q, input logic rise,
                             input logic fall, input logic [7:0] cnt);
        check({tag, ".eq_q"},    {31'd0, eq_q},    {31'd0, q});
        check({tag, ".eq_rise"}, {31'd0, eq_rise}, {31'd0, rise});
        check({tag, ".eq_fall"}, {31'd0, eq_fall}, {31'd0, fall});
        check({tag, ".cnt"},     {24'd0, match_cnt}, {24'd0, cnt});
    endtask

    // Directed combinational sweep: which operand changes, its new value, expected eq.
    logic       sw_is_a [13] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
                                 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [3:0] sw_val  [13] = '{4'd1, 4'd1, 4'd3, 4'd3, 4'd5, 4'd5, 4'd7,
                                 4'd7, 4'd9, 4'd10, 4'd10, 4'd9, 4'd9};
    logic       sw_eq   [13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                                 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        clk_en   = 1'b0;
        clr      = 1'b0;
        rst_n    = 1'b1;
        a        = 4'd0;
        b        = 4'd0;
        #1 rst_n = 1'b0;

        // ---- combinational sweep, clock idle ----
        #1 check("sweep0.eq", {31'd0, eq}, 32'd1);
        for (int i = 0; i < 13; i++) begin
            if (sw_is_a[i]) a = sw_val[i];
            else            b = sw_val[i];
            #1 check($sformatf("sweep%0d.eq", i + 1), {31'd0, eq}, {31'd0, sw_eq[i]});
        end

        // ---- exhaustive 4-bit compare ----
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                a = 4'(ia);
                b = 4'(ib);
                #1;
                check($sformatf("exh_eq_%0d_%0d", ia, ib), {31'd0, eq}, {31'd0, ia == ib});
                check($sformatf("exh_gt_%0d_%0d", ia, ib), {31'd0, gt}, {31'd0, ia > ib});
                check($sformatf("exh_lt_%0d_%0d", ia, ib), {31'd0, lt}, {31'd0, ia < ib});
                check($sformatf("exh_one_%0d_%0d", ia, ib), 32'(eq + gt + lt), 32'd1);
            end
        end

        // ---- registers held in reset, then clocked while still in reset ----
        check_mon("rst_idle", 1'b0, 1'b0, 1'b0, 8'd0);
        a = 4'd4;
        b = 4'd4;
        clk_en = 1'b1;
        tick();
        tick();
        check_mon("rst_held", 1'b0, 1'b0, 1'b0, 8'd0);

        // ---- release with a != b: no pulse from the reset value alone ----
        a = 4'd0;
        b = 4'd1;
        #2 rst_n = 1'b1;
        tick();
        check_mon("rel_ne", 1'b0, 1'b0, 1'b0, 8'd0);

        // ---- edge pulses: a=b=5 for three cycles, then b=6 ----
        a = 4'd5;
        b = 4'd5;
        tick();
        check_mon("edge1", 1'b1, 1'b1, 1'b0, 8'd1);
        tick();
        check_mon("edge2", 1'b1, 1'b0, 1'b0, 8'd2);
        tick();
        check_mon("edge3", 1'b1, 1'b0, 1'b0, 8'd3);
        b = 4'd6;
        tick();
        check_mon("edge4", 1'b0, 1'b0, 1'b1, 8'd3);
        tick();
        check_mon("edge5", 1'b0, 1'b0, 1'b0, 8'd3);
        check("edge5.sat_cnt", {30'd0, s_match_cnt}, 32'd3);

        // ---- asynchronous reset mid-cycle ----
        a = 4'd6;
        tick();
        check_mon("pre_rst", 1'b1, 1'b1, 1'b0, 8'd4);
        #2 rst_n = 1'b0;
        #1 check_mon("async_rst", 1'b0, 1'b0, 1'b0, 8'd0);
        check("async_rst.sat_cnt", {30'd0, s_match_cnt}, 32'd0);
        check("async_rst.eq", {31'd0, eq}, 32'd1);
        b = 4'd7;
        #1 check("async_rst.eq_ne", {31'd0, eq}, 32'd0);
        check("async_rst.lt", {31'd0, lt}, 32'd1);
        b = 4'd6;
        #1 rst_n = 1'b1;

        // ---- first edge after release with eq=1, then saturation at CNT_W=2 ----
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("sat%0d.sat_cnt", k), {30'd0, s_match_cnt},
                  (k < 3) ? 32'(k) : 32'd3);
            check_mon($sformatf("sat%0d", k), 1'b1, (k == 1), 1'b0, 8'(k));
        end

        // ---- operands wiggle between edges: only the edge value counts ----
        b = 4'd0;
        #2 b = 4'd6;
        tick();
        check_mon("glitch", 1'b1, 1'b0, 1'b0, 8'd7);

        // ---- clear priority over a match ----
        clr = 1'b1;
        tick();
        check_mon("clr1", 1'b1, 1'b0, 1'b0, 8'd0);
        check("clr1.sat_cnt", {30'd0, s_match_cnt}, 32'd0);
        clr = 1'b0;
        tick();
        check_mon("clr_rel", 1'b1, 1'b0, 1'b0, 8'd1);
        b = 4'd2;
        tick();
        check_mon("clr_hold", 1'b0, 1'b0, 1'b1, 8'd1);

        // ---- saturation of the 8-bit counter ----
        b = 4'd6;
        for (int k = 0; k < 300; k++) tick();
        check_mon("sat255", 1'b1, 1'b0, 1'b0, 8'd255);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_comp4
`default_nettype wire
